// File: rtl/rock_sequencer.sv
// Rocking-motion duty sequencer for a PWM drive: ramp up, hold, ramp down, pause, repeat.
// Optional macro ROCK_SOFT_STOP_EN: Stop ramps the duty down to zero before returning to IDLE.
module rock_sequencer #(
    parameter int PERIOD        = 24000,
    parameter int STEP          = 400,
    parameter int HOLD_PERIODS  = 50,
    parameter int PAUSE_PERIODS = 50
) (
    input  logic        CLK,
    input  logic        nReset,
    input  logic        Start,
    input  logic        Stop,
    input  logic [15:0] Amplitude,
    output logic [15:0] Duty,
    output logic        Sync,
    output logic        Active,
    output logic [2:0]  State,
    output logic [7:0]  Cycles
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_HOLD      = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_PAUSE     = 3'd4
    } state_e;

    localparam int              CW         = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(PERIOD - 1);
    localparam logic [16:0]     PERIOD_17  = 17'(PERIOD);
    localparam logic [16:0]     STEP_17    = 17'(STEP);
    localparam logic [15:0]     HOLD_LAST  = 16'((HOLD_PERIODS > 0) ? HOLD_PERIODS - 1 : 0);
    localparam logic [15:0]     PAUSE_LAST = 16'((PAUSE_PERIODS > 0) ? PAUSE_PERIODS - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync_q, sync_d;
    logic          start_pend_q, start_pend_d;
    logic          stop_pend_q, stop_pend_d;
    state_e        state_q, state_d;
    logic [15:0]   duty_q, duty_d;
    logic [15:0]   target_q, target_d;
    logic [15:0]   per_cnt_q, per_cnt_d;
    logic [7:0]    cycles_q, cycles_d;
    logic          active_q, active_d;
`ifdef ROCK_SOFT_STOP_EN
    logic          stopping_q, stopping_d;
`endif

    logic          boundary_s;
    logic          start_now_s;
    logic          stop_now_s;
    logic [16:0]   sum_s;
    logic [15:0]   diff_s;
    logic          down_done_s;
    logic [15:0]   amp_clamp_s;

    // Next-state logic: period counter, pending requests and the per-boundary sequencer step.
    always_comb begin
        boundary_s   = (cnt_q == CNT_LAST);
        cnt_d        = boundary_s ? {CW{1'b0}} : cnt_q + CW'(1);
        sync_d       = (cnt_d == CNT_LAST);
        start_now_s  = start_pend_q | Start;
        stop_now_s   = stop_pend_q | Stop;
        sum_s        = {1'b0, duty_q} + STEP_17;
        down_done_s  = ({1'b0, duty_q} <= STEP_17);
        diff_s       = down_done_s ? 16'd0 : duty_q - STEP_17[15:0];
        amp_clamp_s  = ({1'b0, Amplitude} > PERIOD_17) ? PERIOD_17[15:0] : Amplitude;
        state_d      = state_q;
        duty_d       = duty_q;
        target_d     = target_q;
        per_cnt_d    = per_cnt_q;
        cycles_d     = cycles_q;
`ifdef ROCK_SOFT_STOP_EN
        stopping_d   = stopping_q;
`endif

        if (boundary_s) begin
            // Requests are consumed at every boundary, whether acted on or not.
            start_pend_d = 1'b0;
            stop_pend_d  = 1'b0;
            if (stop_now_s && (state_q != S_IDLE)) begin
`ifdef ROCK_SOFT_STOP_EN
                case (state_q)
                    S_RAMP_UP, S_HOLD: begin
                        state_d    = S_RAMP_DOWN;
                        stopping_d = 1'b1;
                    end
                    S_RAMP_DOWN: begin
                        duty_d = diff_s;
                        if (down_done_s) begin
                            state_d    = S_IDLE;
                            stopping_d = 1'b0;
                        end else begin
                            stopping_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d    = S_IDLE;
                        duty_d     = 16'd0;
                        stopping_d = 1'b0;
                    end
                endcase
`else
                state_d = S_IDLE;
                duty_d  = 16'd0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        duty_d = 16'd0;
                        if (start_now_s && !stop_now_s) begin
                            target_d = amp_clamp_s;
                            cycles_d = 8'd0;
                            state_d  = S_RAMP_UP;
                        end else begin
                            state_d  = S_IDLE;
                        end
                    end
                    S_RAMP_UP: begin
                        if (sum_s >= {1'b0, target_q}) begin
                            duty_d    = target_q;
                            per_cnt_d = 16'd0;
                            state_d   = (HOLD_PERIODS == 0) ? S_RAMP_DOWN : S_HOLD;
                        end else begin
                            duty_d    = sum_s[15:0];
                        end
                    end
                    S_HOLD: begin
                        if (per_cnt_q >= HOLD_LAST) begin
                            state_d   = S_RAMP_DOWN;
                        end else begin
                            per_cnt_d = per_cnt_q + 16'd1;
                        end
                    end
                    S_RAMP_DOWN: begin
                        duty_d = diff_s;
                        if (!down_done_s) begin
                            state_d = S_RAMP_DOWN;
`ifdef ROCK_SOFT_STOP_EN
                        end else if (stopping_q) begin
                            state_d    = S_IDLE;
                            stopping_d = 1'b0;
`endif
                        end else if (PAUSE_PERIODS == 0) begin
                            cycles_d = cycles_q + 8'd1;
                            target_d = amp_clamp_s;
                            state_d  = S_RAMP_UP;
                        end else begin
                            per_cnt_d = 16'd0;
                            state_d   = S_PAUSE;
                        end
                    end
                    S_PAUSE: begin
                        duty_d = 16'd0;
                        if (per_cnt_q >= PAUSE_LAST) begin
                            cycles_d = cycles_q + 8'd1;
                            target_d = amp_clamp_s;
                            state_d  = S_RAMP_UP;
                        end else begin
                            per_cnt_d = per_cnt_q + 16'd1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        duty_d  = 16'd0;
                    end
                endcase
            end
        end else begin
            start_pend_d = start_now_s;
            stop_pend_d  = stop_now_s;
        end
        active_d = (state_d != S_IDLE);
    end

    // State and output registers, cleared immediately by nReset.
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            cnt_q        <= {CW{1'b0}};
            sync_q       <= 1'b0;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            state_q      <= S_IDLE;
            duty_q       <= 16'd0;
            target_q     <= 16'd0;
            per_cnt_q    <= 16'd0;
            cycles_q     <= 8'd0;
            active_q     <= 1'b0;
`ifdef ROCK_SOFT_STOP_EN
            stopping_q   <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
            state_q      <= state_d;
            duty_q       <= duty_d;
            target_q     <= target_d;
            per_cnt_q    <= per_cnt_d;
            cycles_q     <= cycles_d;
            active_q     <= active_d;
`ifdef ROCK_SOFT_STOP_EN
            stopping_q   <= stopping_d;
`endif
        end
    end

    assign Duty   = duty_q;
    assign Sync   = sync_q;
    assign Active = active_q;
    assign State  = state_q;
    assign Cycles = cycles_q;

endmodule
